// File: rtl/fpio_fifo_wr_arb.sv
// Round-robin, burst-locking arbiter sharing one fpio FIFO write port between N_REQ producers.
// The owner's request/data pass straight through to the FIFO while it holds the grant.
module fpio_fifo_wr_arb #(
    parameter int N_REQ      = 4,
    parameter int FIFO_BITS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req_en,
    input  logic [N_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [N_REQ-1:0]               req_ack,
    output logic [N_REQ*(FIFO_BITS+1)-1:0] req_avail,
    input  logic [FIFO_BITS:0]             fifo_avail,
    output logic [DATA_WIDTH-1:0]          fifo_data,
    output logic                           fifo_en,
    input  logic                           fifo_ack,
    output logic [N_REQ-1:0]               grant,
    output logic                           busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         last_q, last_d;
    logic [BW-1:0]         burst_cnt_q, burst_cnt_d;

    logic [DATA_WIDTH-1:0] req_words_s [N_REQ];
    logic                  sel_found_s;
    logic [IW-1:0]         sel_idx_s;
    logic [IW-1:0]         scan_idx_s;
    logic                  xfer_s;
    logic [BW-1:0]         burst_inc_s;

    // Slice the flat request data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_words_s[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin pick: first active request starting just after the last released owner.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        scan_idx_s  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx_s = IW'((int'(last_q) + k) % N_REQ);
            if (!sel_found_s && req_en[scan_idx_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = scan_idx_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Next-state and datapath: quiet in IDLE, combinational pass-through of the owner in GRANT.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        fifo_en     = 1'b0;
        fifo_data   = '0;
        req_ack     = '0;
        xfer_s      = 1'b0;
        burst_inc_s = burst_cnt_q + BW'(1);
        case (state_q)
            ST_IDLE: begin
                if (sel_found_s) begin
                    state_d     = ST_GRANT;
                    owner_d     = sel_idx_s;
                    grant_d     = N_REQ'(1) << sel_idx_s;
                    burst_cnt_d = '0;
                end else begin
                    grant_d = '0;
                end
            end
            ST_GRANT: begin
                fifo_en          = req_en[owner_q];
                fifo_data        = fifo_en ? req_words_s[owner_q] : '0;
                req_ack[owner_q] = fifo_ack & req_en[owner_q];
                xfer_s           = fifo_en & fifo_ack;
                if (xfer_s) begin
                    burst_cnt_d = burst_inc_s;
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
                // Release once the owner goes quiet or its burst quota is used up.
                if (!req_en[owner_q] || (xfer_s && (burst_inc_s == BW'(MAX_BURST)))) begin
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                    last_d      = owner_q;
                    burst_cnt_d = '0;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_d     = '0;
                burst_cnt_d = '0;
            end
        endcase
    end

    // State register; last starts at N_REQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            last_q      <= IW'(N_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q == ST_GRANT);
    assign req_avail = {N_REQ{fifo_avail}};

endmodule

// File: tb/tb_fpio_fifo_wr_arb.sv
// Directed and random scoreboard bench for fpio_fifo_wr_arb (N_REQ=4, MAX_BURST=4).
module tb_fpio_fifo_wr_arb;

    logic         clock;
    logic         reset;
    logic [3:0]   req_en;
    logic [127:0] req_data;
    logic [3:0]   req_ack;
    logic [19:0]  req_avail;
    logic [4:0]   fifo_avail;
    logic [31:0]  fifo_data;
    logic         fifo_en;
    logic         fifo_ack;
    logic [3:0]   grant;
    logic         busy;

    int n_checks = 0;
    int n_fails  = 0;

    fpio_fifo_wr_arb #(
        .N_REQ(4), .FIFO_BITS(4), .DATA_WIDTH(32), .MAX_BURST(4)
    ) dut (
        .clock(clock), .reset(reset), .req_en(req_en), .req_data(req_data),
        .req_ack(req_ack), .req_avail(req_avail), .fifo_avail(fifo_avail),
        .fifo_data(fifo_data), .fifo_en(fifo_en), .fifo_ack(fifo_ack),
        .grant(grant), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req_en   = 4'b0000;
        fifo_ack = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [23:0] seq    [4];
    logic [23:0] sb_seq [4];
    logic [3:0]  accepted;
    logic [3:0]  prev_grant;
    int          run_len;
    int          n_beats;
    int          n_sent;
    int          idx;

    initial begin
        reset      = 1'b1;
        req_en     = 4'b0000;
        req_data   = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        fifo_avail = 5'd9;
        fifo_ack   = 1'b1;
        do_reset();

        // Reset state
        check_eq("rst_grant",   64'(grant),     64'(4'b0000));
        check_eq("rst_busy",    64'(busy),      64'(1'b0));
        check_eq("rst_fifo_en", 64'(fifo_en),   64'(1'b0));
        check_eq("rst_data",    64'(fifo_data), 64'(32'h0));
        check_eq("rst_ack",     64'(req_ack),   64'(4'b0000));
        check_eq("rst_last",    64'(dut.last_q), 64'(2'd3));
        check_eq("avail_rep",   64'(req_avail), 64'({5'd9, 5'd9, 5'd9, 5'd9}));
        fifo_avail = 5'd16;
        #1;
        check_eq("avail_rep2",  64'(req_avail), 64'({5'd16, 5'd16, 5'd16, 5'd16}));

        // Single requester, three words
        req_en   = 4'b0001;
        req_data[31:0] = 32'h1111_0000;
        #1;
        check_eq("t1_idle_en", 64'(fifo_en), 64'(1'b0));
        step();
        check_eq("t1_grant", 64'(grant), 64'(4'b0001));
        check_eq("t1_busy",  64'(busy),  64'(1'b1));
        for (int w = 0; w < 3; w++) begin
            req_data[31:0] = 32'h1111_0000 + 32'(w);
            #1;
            check_eq("t1_en",   64'(fifo_en),   64'(1'b1));
            check_eq("t1_ack",  64'(req_ack),   64'(4'b0001));
            check_eq("t1_data", 64'(fifo_data), 64'(32'h1111_0000 + 32'(w)));
            step();
        end
        req_en = 4'b0000;
        #1;
        check_eq("t1_drop_grant", 64'(grant),     64'(4'b0001));
        check_eq("t1_drop_en",    64'(fifo_en),   64'(1'b0));
        check_eq("t1_drop_data",  64'(fifo_data), 64'(32'h0));
        step();
        check_eq("t1_released", 64'(grant), 64'(4'b0000));

        // All four requesting: round robin 0,1,2,3,0 with 4-beat bursts and idle gaps
        do_reset();
        req_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        req_en   = 4'b1111;
        begin
            int owners [5] = '{0, 1, 2, 3, 0};
            for (int n = 0; n < 5; n++) begin
                step();
                check_eq("rr_grant", 64'(grant), 64'(oh(owners[n])));
                for (int b = 0; b < 4; b++) begin
                    check_eq("rr_en",   64'(fifo_en),   64'(1'b1));
                    check_eq("rr_ack",  64'(req_ack),   64'(oh(owners[n])));
                    check_eq("rr_data", 64'(fifo_data), 64'(32'hA000_0000 | 32'(owners[n])));
                    step();
                end
                check_eq("rr_gap_grant", 64'(grant), 64'(4'b0000));
                check_eq("rr_gap_en",    64'(fifo_en), 64'(1'b0));
            end
        end

        // Owner 2 stalled by a full FIFO for 10 cycles
        do_reset();
        req_en = 4'b0100;
        step();
        fifo_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_eq("stall_grant", 64'(grant),           64'(4'b0100));
            check_eq("stall_ack",   64'(req_ack),         64'(4'b0000));
            check_eq("stall_data",  64'(fifo_data),       64'(32'hA000_0002));
            check_eq("stall_cnt",   64'(dut.burst_cnt_q), 64'(0));
            step();
        end
        fifo_ack = 1'b1;
        #1;
        check_eq("resume_ack", 64'(req_ack), 64'(4'b0100));
        step();
        check_eq("resume_cnt",   64'(dut.burst_cnt_q), 64'(1));
        check_eq("resume_grant", 64'(grant),           64'(4'b0100));
        req_en = 4'b0000;
        step();
        check_eq("stall_release", 64'(grant), 64'(4'b0000));

        // Non-owner request during a burst is held off; it wins next (after last=1)
        do_reset();
        req_en = 4'b0010;
        step();
        check_eq("nb_grant", 64'(grant), 64'(4'b0010));
        step();
        req_en = 4'b1010;
        for (int b = 0; b < 3; b++) begin
            #1;
            check_eq("nb_ack", 64'(req_ack), 64'(4'b0010));
            step();
        end
        check_eq("nb_release", 64'(grant), 64'(4'b0000));
        step();
        check_eq("nb_next", 64'(grant), 64'(4'b1000));
        req_en = 4'b0000;
        step();
        step();

        // Reset during the second beat of a burst
        do_reset();
        req_en = 4'b0001;
        step();
        step();
        check_eq("mr_beat2_en", 64'(fifo_en), 64'(1'b1));
        reset = 1'b1;
        step();
        check_eq("mr_grant", 64'(grant),       64'(4'b0000));
        check_eq("mr_en",    64'(fifo_en),     64'(1'b0));
        check_eq("mr_busy",  64'(busy),        64'(1'b0));
        check_eq("mr_last",  64'(dut.last_q),  64'(2'd3));
        reset  = 1'b0;
        req_en = 4'b0110;
        step();
        check_eq("mr_regrant", 64'(grant), 64'(4'b0010));

        // Random traffic against a per-requester sequence scoreboard
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i]    = 24'd0;
            sb_seq[i] = 24'd0;
        end
        prev_grant = 4'b0000;
        run_len    = 0;
        n_beats    = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_en[i] && ($urandom_range(0, 2) == 0)) begin
                    req_en[i] = 1'b1;
                end
                req_data[i*32 +: 32] = {8'(i), seq[i]};
            end
            fifo_ack = ($urandom_range(0, 3) != 0);
            #1;
            check_eq("sb_onehot", 64'($countones(grant) <= 1), 64'(1'b1));
            check_eq("sb_b2b", 64'((prev_grant != 4'b0000) && (grant != 4'b0000) && (prev_grant != grant)), 64'(1'b0));
            if (grant == 4'b0000) begin
                run_len = 0;
            end
            if (fifo_en && fifo_ack) begin
                check_eq("sb_ack_owner", 64'(req_ack), 64'(grant));
                idx = 0;
                for (int i = 0; i < 4; i++) begin
                    if (grant[i]) idx = i;
                end
                check_eq("sb_data", 64'(fifo_data), 64'({8'(idx), sb_seq[idx]}));
                sb_seq[idx] = sb_seq[idx] + 24'd1;
                n_beats++;
                run_len++;
                check_eq("sb_burst_len", 64'(run_len <= 4), 64'(1'b1));
            end
            accepted   = req_en & req_ack;
            prev_grant = grant;
            step();
            for (int i = 0; i < 4; i++) begin
                if (accepted[i]) begin
                    seq[i] = seq[i] + 24'd1;
                    if ($urandom_range(0, 1) == 0) req_en[i] = 1'b0;
                end
            end
        end
        n_sent = 0;
        for (int i = 0; i < 4; i++) n_sent += int'(seq[i]);
        check_eq("sb_no_loss", 64'(n_beats), 64'(n_sent));
        check_eq("sb_activity", 64'(n_beats > 1000), 64'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
